sw_score_collector: RTL and testbench

Downstream stage of the Smith-Waterman scoring array: consumes one biased score per database sequence from the scoring module's `result`/`vld` pair and removes the bias. Tags each result with its sequence index and keeps a running best hit. Pushes every result at or above a runtime threshold into a small FIFO that the host or readout logic drains through a valid/ready handshake.

---
 rtl/sw_score_collector.sv | 210 +++++++++++++++++++++
 tb/tb_sw_score_collector.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sw_score_collector.sv
// sw_score_collector
// ------------------
// Collects the scores produced by the Smith-Waterman scoring array, one
// biased score per database sequence. Each score is unbiased by ZERO and
// tagged with its sequence index. A running best hit is kept. Any result
// at or above a runtime threshold is queued in a small first-word-fall-through
// FIFO, which the host drains through a valid/ready handshake.
//
// Build option:
//   SW_COLLECTOR_BEST_EN  defined   -> best-score tracker is built
//                         undefined -> best_score / best_idx tied to 0
//
// Ports:
//   clk         in   1             rising-edge clock
//   rst         in   1             asynchronous active-high reset
//   vld_in      in   1             one scoring result present this cycle
//   score_in    in   SCORE_WIDTH   biased score
//   threshold   in   SCORE_WIDTH   unbiased hit threshold
//   clear       in   1             synchronous clear of counters/best/FIFO/flags
//   out_valid   out  1             FIFO head valid
//   out_ready   in   1             consumer accepts head
//   out_idx     out  IDX_WIDTH     sequence index of head entry
//   out_score   out  SCORE_WIDTH   unbiased score of head entry
//   fifo_count  out  LOG_DEPTH+1   entries held
//   seq_count   out  IDX_WIDTH     results received since reset/clear
//   best_score  out  SCORE_WIDTH   highest unbiased score seen
//   best_idx    out  IDX_WIDTH     index of best_score
//   overflow    out  1             sticky: a hit was dropped on a full FIFO
module sw_score_collector #(
  parameter int SCORE_WIDTH = 12,
  parameter int ZERO        = 2**(SCORE_WIDTH-1),
  parameter int IDX_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOG_DEPTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_in,
  input  logic [SCORE_WIDTH-1:0] score_in,
  input  logic [SCORE_WIDTH-1:0] threshold,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_WIDTH-1:0]   out_idx,
  output logic [SCORE_WIDTH-1:0] out_score,
  output logic [LOG_DEPTH:0]     fifo_count,
  output logic [IDX_WIDTH-1:0]   seq_count,
  output logic [SCORE_WIDTH-1:0] best_score,
  output logic [IDX_WIDTH-1:0]   best_idx,
  output logic                   overflow
);

  localparam int                     ENTRY_W  = IDX_WIDTH + SCORE_WIDTH;
  localparam logic [SCORE_WIDTH-1:0] ZERO_V   = SCORE_WIDTH'(ZERO);
  localparam logic [LOG_DEPTH:0]     FULL_CNT = (LOG_DEPTH+1)'(FIFO_DEPTH);
  localparam logic [LOG_DEPTH-1:0]   PTR_ONE  = LOG_DEPTH'(1);
  localparam logic [LOG_DEPTH:0]     CNT_ONE  = (LOG_DEPTH+1)'(1);
  localparam logic [IDX_WIDTH-1:0]   IDX_ONE  = IDX_WIDTH'(1);

  logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
  logic [LOG_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]     count_q, count_d;
  logic [IDX_WIDTH-1:0]   seq_count_q, seq_count_d;
  logic                   overflow_q, overflow_d;

  logic [SCORE_WIDTH-1:0] unbiased;
  logic                   hit;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   mem_we;
  logic [ENTRY_W-1:0]     head;

  // Unbias, hit detection and next-state of FIFO bookkeeping and counters
  always_comb begin
    // Scores below the bias clamp to zero instead of wrapping.
    if (score_in >= ZERO_V) begin
      unbiased = score_in - ZERO_V;
    end else begin
      unbiased = '0;
    end
    hit  = vld_in && (unbiased >= threshold);
    full = (count_q == FULL_CNT);
    // Pop only when something is held; out_ready on an empty FIFO is ignored.
    pop  = (count_q != '0) && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = hit && (!full || pop);
    mem_we = push && !clear;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    seq_count_d = seq_count_q;
    overflow_d  = overflow_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      seq_count_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (hit && !push) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (vld_in) begin
        seq_count_d = seq_count_q + IDX_ONE;
      end else begin
        seq_count_d = seq_count_q;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      seq_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      seq_count_q <= seq_count_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {seq_count_q, unbiased};
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  // Head is forced to zero when empty so reset/clear show all-zero outputs.
  assign out_idx    = out_valid ? head[ENTRY_W-1:SCORE_WIDTH] : '0;
  assign out_score  = out_valid ? head[SCORE_WIDTH-1:0] : '0;
  assign fifo_count = count_q;
  assign seq_count  = seq_count_q;
  assign overflow   = overflow_q;

`ifdef SW_COLLECTOR_BEST_EN
  logic                   best_vld_q, best_vld_d;
  logic [SCORE_WIDTH-1:0] best_score_q, best_score_d;
  logic [IDX_WIDTH-1:0]   best_idx_q, best_idx_d;

  // Best tracker: first result always loads, later ones only on strictly higher score
  always_comb begin
    best_vld_d   = best_vld_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    if (clear) begin
      best_vld_d   = 1'b0;
      best_score_d = '0;
      best_idx_d   = '0;
    end else if (vld_in && (!best_vld_q || (unbiased > best_score_q))) begin
      best_vld_d   = 1'b1;
      best_score_d = unbiased;
      best_idx_d   = seq_count_q;
    end else begin
      best_vld_d   = best_vld_q;
      best_score_d = best_score_q;
      best_idx_d   = best_idx_q;
    end
  end

  // Best tracker registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_vld_q   <= 1'b0;
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else begin
      best_vld_q   <= best_vld_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
    end
  end

  assign best_score = best_score_q;
  assign best_idx   = best_idx_q;
`else
  assign best_score = '0;
  assign best_idx   = '0;
`endif

endmodule

// File: tb/tb_sw_score_collector.sv
// Testbench for sw_score_collector. A queue holds the expected FIFO contents;
// the stimulus process pushes into it when a hit should be accepted and a
// separate negedge monitor compares the DUT against it and pops on handshake.
module tb_sw_score_collector;

  localparam int SW    = 12;
  localparam int IW    = 16;
  localparam int DEPTH = 8;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          vld_in     = 1'b0;
  logic [SW-1:0] score_in   = '0;
  logic [SW-1:0] threshold  = '0;
  logic          clear      = 1'b0;
  logic          out_ready  = 1'b0;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic [SW-1:0] out_score;
  logic [3:0]    fifo_count;
  logic [IW-1:0] seq_count;
  logic [SW-1:0] best_score;
  logic [IW-1:0] best_idx;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [IW+SW-1:0] exp_q[$];
  logic [IW-1:0]    m_seq   = '0;
  logic [SW-1:0]    m_bscore = '0;
  logic [IW-1:0]    m_bidx  = '0;
  bit               m_bvld  = 1'b0;
  bit               m_ovf   = 1'b0;

  sw_score_collector dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .score_in(score_in),
    .threshold(threshold), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_score(out_score),
    .fifo_count(fifo_count), .seq_count(seq_count), .best_score(best_score),
    .best_idx(best_idx), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_seq = '0; m_bscore = '0; m_bidx = '0; m_bvld = 1'b0; m_ovf = 1'b0;
  endtask

  // Model of one clock edge, called after the monitor has already popped.
  task automatic model_step(input logic v, input logic [SW-1:0] s,
                            input logic [SW-1:0] th, input logic clr);
    logic [SW-1:0] u;
    if (clr) begin
      model_reset();
    end else if (v) begin
      u = (s >= 12'd2048) ? (s - 12'd2048) : 12'd0;
      if (u >= th) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({m_seq, u});
        else m_ovf = 1'b1;
      end
      if (!m_bvld || u > m_bscore) begin
        m_bvld = 1'b1; m_bscore = u; m_bidx = m_seq;
      end
      m_seq = m_seq + 16'd1;
    end
  endtask

  task automatic cycle(input logic v, input logic [SW-1:0] s, input logic [SW-1:0] th,
                       input logic rdy, input logic clr);
    vld_in = v; score_in = s; threshold = th; out_ready = rdy; clear = clr;
    @(posedge clk);
    model_step(v, s, th, clr);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 12'd0, 12'd0, rdy, 1'b0);
  endtask

  // Monitor: compares outputs against the model and pops on handshake
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("fifo_count", {28'd0, fifo_count}, exp_q.size());
      chk("seq_count", {16'd0, seq_count}, {16'd0, m_seq});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef SW_COLLECTOR_BEST_EN
      chk("best_score", {20'd0, best_score}, {20'd0, m_bscore});
      chk("best_idx", {16'd0, best_idx}, {16'd0, m_bidx});
`else
      chk("best_score", {20'd0, best_score}, 32'd0);
      chk("best_idx", {16'd0, best_idx}, 32'd0);
`endif
      if (exp_q.size() != 0) begin
        chk("head_idx", {16'd0, out_idx}, {16'd0, exp_q[0][IW+SW-1:SW]});
        chk("head_score", {20'd0, out_score}, {20'd0, exp_q[0][SW-1:0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_seq", {16'd0, seq_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic: two hits out of three, drained immediately
    cycle(1'b1, 12'd2073, 12'd20, 1'b1, 1'b0);
    cycle(1'b1, 12'd2058, 12'd20, 1'b1, 1'b0);
    cycle(1'b1, 12'd2078, 12'd20, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("basic_seq", {16'd0, seq_count}, 32'd3);
`ifdef SW_COLLECTOR_BEST_EN
    chk("basic_best", {20'd0, best_score}, 32'd30);
    chk("basic_bidx", {16'd0, best_idx}, 32'd2);
`endif

    // Asynchronous reset mid-cycle with three entries queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 12'd2100, 12'd20, 1'b0, 1'b0);
    chk("pre_rst_count", {28'd0, fifo_count}, 32'd3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_count", {28'd0, fifo_count}, 32'd0);
    chk("arst_seq", {16'd0, seq_count}, 32'd0);
    chk("arst_idx", {16'd0, out_idx}, 32'd0);
    chk("arst_score", {20'd0, out_score}, 32'd0);
    chk("arst_best", {20'd0, best_score}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1, 1'b0);

    // Overflow: nine hits with no consumer, then drain
    for (int i = 0; i < 9; i++) cycle(1'b1, 12'd2100, 12'd20, 1'b0, 1'b0);
    chk("ovf_count", {28'd0, fifo_count}, 32'd8);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    idle(10, 1'b1);
    chk("ovf_drained", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 12'd0, 12'd0, 1'b0, 1'b1);

    // Full FIFO with a simultaneous pop and push
    for (int i = 0; i < 8; i++) cycle(1'b1, 12'd2100, 12'd20, 1'b0, 1'b0);
    cycle(1'b1, 12'd2100, 12'd20, 1'b1, 1'b0);
    chk("fullpop_count", {28'd0, fifo_count}, 32'd8);
    chk("fullpop_ovf", {31'd0, overflow}, 32'd0);
    idle(10, 1'b1);
    cycle(1'b0, 12'd0, 12'd0, 1'b0, 1'b1);

    // Clamp and tie behaviour at threshold 0
    cycle(1'b1, 12'd2000, 12'd0, 1'b0, 1'b0);
    cycle(1'b1, 12'd2048, 12'd0, 1'b0, 1'b0);
    cycle(1'b1, 12'd2078, 12'd0, 1'b0, 1'b0);
    cycle(1'b1, 12'd2078, 12'd0, 1'b0, 1'b0);
    chk("clamp_count", {28'd0, fifo_count}, 32'd4);
    idle(5, 1'b1);

    // Clear with a result in the same cycle
    cycle(1'b1, 12'd2100, 12'd20, 1'b0, 1'b0);
    cycle(1'b1, 12'd2100, 12'd20, 1'b0, 1'b1);
    chk("clr_seq", {16'd0, seq_count}, 32'd0);
    chk("clr_count", {28'd0, fifo_count}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [SW-1:0] s;
      if ($urandom_range(0, 3) == 0) s = SW'($urandom_range(0, 4095));
      else s = SW'($urandom_range(1990, 2150));
      cycle(logic'($urandom_range(0, 9) < 7), s, SW'($urandom_range(0, 120)),
            logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 99) < 2));
    end
    idle(12, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
